// File: rtl/fibonacci_index_finder.sv
// Inverse Fibonacci search: finds the largest k with F(k) <= value, one term per clock,
// and flags whether value is itself a Fibonacci number.
module fibonacci_index_finder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] index,
  output logic             is_fib
);

  typedef enum logic {IDLE, SEARCH} state_t;

  // Two guard bits let the overshooting term F(m) and its successor be held exactly.
  localparam int TW = WIDTH + 2;
  localparam logic [IDX_W-1:0] K_ONE = IDX_W'(1);
  localparam logic [TW-1:0]    T_ONE = TW'(1);

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [TW-1:0]    a;
  logic [TW-1:0]    b;
  logic [IDX_W-1:0] k;
  logic [TW-1:0]    target_ext;

  assign target_ext = TW'(target);

  // NOTE: every register here is state, so all updates are non-blocking; mixing in
  // blocking assignments would make the a/b swap order-dependent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      target <= '0;
      a      <= '0;
      b      <= '0;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      index  <= '0;
      is_fib <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            target <= value;
            a      <= '0;
            b      <= T_ONE;
            k      <= '0;
            busy   <= 1'b1;
            index  <= '0;
            is_fib <= 1'b0;
            state  <= SEARCH;
          end
        end
        SEARCH: begin
          if (a == target_ext) begin
            index  <= k;
            is_fib <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (a > target_ext) begin
            // a starts at 0 <= target, so overshoot always happens with k >= 1.
            index  <= k - K_ONE;
            is_fib <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            a <= b;
            b <= a + b;
            k <= k + K_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_index_finder.sv
// Self-checking bench for fibonacci_index_finder: directed vectors, handshake corners,
// Fibonacci loopback and randomized queries against a plain-arithmetic reference.
module tb_fibonacci_index_finder;

  localparam int WIDTH  = 8;
  localparam int IDX_W  = 5;
  localparam int BUDGET = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] index;
  logic             is_fib;

  int checks = 0;
  int errors = 0;
  int both_high = 0;

  typedef struct {
    int value;
    int idx;
    int fib;
    int edges;
  } vec_t;

  vec_t vecs[10];

  fibonacci_index_finder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .index(index), .is_fib(is_fib)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) both_high++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the sequence with integers until a term reaches the value.
  function automatic void model(input int v, output int idx, output int fib, output int edges);
    int fa, fb, t, kk;
    fa = 0; fb = 1; kk = 0;
    while (fa < v) begin
      t = fa + fb; fa = fb; fb = t; kk++;
    end
    fib   = (fa == v) ? 1 : 0;
    idx   = fib ? kk : kk - 1;
    edges = kk + 1;
  endfunction

  function automatic int fib_of(input int n);
    int fa, fb, t;
    fa = 0; fb = 1;
    for (int i = 0; i < n; i++) begin
      t = fa + fb; fa = fb; fb = t;
    end
    return fa;
  endfunction

  // Drive start for one edge; leaves time at #1 after the accepting edge.
  task automatic launch(input int v);
    @(negedge clk);
    start = 1'b1;
    value = WIDTH'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (sampled #1 after each edge); -1 on timeout.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic run_search(input string name, input int v, input int e_idx,
                            input int e_fib, input int e_edges);
    int edges;
    launch(v);
    check({name, " busy_after_accept"}, int'(busy), 1);
    check({name, " index_cleared"}, int'(index), 0);
    wait_done(edges);
    check({name, " latency"}, edges, e_edges);
    check({name, " index"}, int'(index), e_idx);
    check({name, " is_fib"}, int'(is_fib), e_fib);
    check({name, " busy_at_done"}, int'(busy), 0);
    @(posedge clk);
    #1;
    check({name, " done_one_cycle"}, int'(done), 0);
    check({name, " index_held"}, int'(index), e_idx);
  endtask

  initial begin
    int edges, e_idx, e_fib, e_edges, v, seen_done;

    vecs[0] = '{0,   0,  1, 1};
    vecs[1] = '{1,   1,  1, 2};
    vecs[2] = '{2,   3,  1, 4};
    vecs[3] = '{5,   5,  1, 6};
    vecs[4] = '{4,   4,  0, 6};
    vecs[5] = '{10,  6,  0, 8};
    vecs[6] = '{233, 13, 1, 14};
    vecs[7] = '{255, 13, 0, 15};
    vecs[8] = '{200, 12, 0, 14};
    vecs[9] = '{100, 11, 0, 13};

    rst = 1'b1; start = 1'b0; value = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset index", int'(index), 0);
    check("reset is_fib", int'(is_fib), 0);

    foreach (vecs[i])
      run_search($sformatf("vec%0d(v=%0d)", i, vecs[i].value),
                 vecs[i].value, vecs[i].idx, vecs[i].fib, vecs[i].edges);

    // start pulsed mid-search with a different value is ignored
    launch(200);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; value = 8'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(edges);
    check("ignore latency", edges, 10);
    check("ignore index", int'(index), 12);
    check("ignore is_fib", int'(is_fib), 0);

    // start raised in the done cycle: back-to-back acceptance
    start = 1'b1; value = 8'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b done_low", int'(done), 0);
    check("b2b busy", int'(busy), 1);
    wait_done(edges);
    check("b2b latency", edges, 7);
    check("b2b index", int'(index), 6);
    check("b2b is_fib", int'(is_fib), 1);

    // asynchronous reset mid-search, then no done pulse may follow
    launch(200);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst index", int'(index), 0);
    check("midrst is_fib", int'(is_fib), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1;
    end
    check("midrst no_done", seen_done, 0);

    // loopback of F(0..13) as query values
    for (int n = 0; n <= 13; n++) begin
      e_idx = (n == 2) ? 1 : n;
      model(fib_of(n), e_idx, e_fib, e_edges);
      launch(fib_of(n));
      wait_done(edges);
      check($sformatf("loop n=%0d is_fib", n), int'(is_fib), 1);
      check($sformatf("loop n=%0d index", n), int'(index), (n == 2) ? 1 : n);
      check($sformatf("loop n=%0d latency", n), edges, e_edges);
    end

    // randomized queries against the reference
    for (int r = 0; r < 30; r++) begin
      v = int'($urandom_range(0, 255));
      model(v, e_idx, e_fib, e_edges);
      launch(v);
      wait_done(edges);
      check($sformatf("rand v=%0d latency", v), edges, e_edges);
      check($sformatf("rand v=%0d index", v), int'(index), e_idx);
      check($sformatf("rand v=%0d is_fib", v), int'(is_fib), e_fib);
    end

    check("busy_done_exclusive", both_high, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fibonacci_index_finder.md
Name: fibonacci_index_finder

Overview:
Inverse of the Fibonacci generator. Given a value, the block finds the largest index k with F(k) <= value and flags whether value is exactly a Fibonacci number. It iterates the sequence one term per clock and uses the same start/result handshake style as the generator, so a bench can chain the generator's fib output into this block's value input.
Sequence definition: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).

Parameters:
- WIDTH, 8, width of the value input.
- IDX_W, 5, width of the index output; must hold the largest reachable index (13 for WIDTH=8, 24 for WIDTH=16).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- value  input  WIDTH  query value; captured on the edge that accepts start
- busy  output  1  high while a search is in progress
- done  output  1  one-cycle pulse; result is valid
- index  output  IDX_W  largest k with F(k) <= value
- is_fib  output  1  1 if value == F(index)

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, index=0, is_fib=0; internal terms cleared. Reset mid-search aborts the search with no done pulse.
- States: IDLE, SEARCH.
- IDLE + start=1 at edge E0:
  - capture value; a=0, b=1, k=0
  - busy=1, index=0, is_fib=0; go to SEARCH
- IDLE + start=0: stay in IDLE. index and is_fib hold their last result.
- SEARCH, each edge: compare a (=F(k)) with the captured value.
  - a == value: index=k, is_fib=1, done=1, busy=0, go to IDLE.
  - a > value: index=k-1, is_fib=0, done=1, busy=0, go to IDLE.
  - a < value: a<=b, b<=a+b, k<=k+1, stay in SEARCH.
- Tie rule: value=1 matches at k=1 (first hit wins), never k=2.
- Arithmetic: a and b are WIDTH+2 bits wide, unsigned, and never truncated. The compare is zero-extended, so no wrap-around can produce a false match. k is IDX_W bits.
- Latency: done is high in the cycle after edge E(m+1), where m is the terminating k. Exact match at index k gives k+1 edges after acceptance. Overshoot at F(m) > value gives m+1 edges.
- done: exactly one cycle wide. busy falls at the same edge done rises. busy and done are never high together.
- start while busy: ignored, and value changes are ignored.
- start high in the done cycle: accepted as a new request at the next edge (back-to-back allowed).
- start held high continuously: a new search begins each time IDLE is re-entered.
- Results (index, is_fib) are stable from done until the next accepted start clears them.

Test Plan:
1. rst=1 for 2 cycles, then 0, with start=0 → busy=0, done=0, index=0, is_fib=0. Assert rst mid-SEARCH (value=200, after 3 edges) → outputs zero immediately (asynchronously), no done pulse ever follows.
2. value=0, start pulse → done after 1 edge, index=0, is_fib=1. value=1 → done after 2 edges, index=1, is_fib=1.
3. value=5 → done after 6 edges, index=5, is_fib=1. value=4 → done after 6 edges, index=4, is_fib=0. value=10 → done after 8 edges, index=6, is_fib=0.
4. WIDTH=8 extremes:
   - value=233 → index=13, is_fib=1, after 14 edges.
   - value=255 → index=13, is_fib=0, after 15 edges.
   - Check internal sum does not wrap (F(14)=377).
5. Handshake:
   - Pulse start again with value=100 during a search for 200 → ignored; result index=12, is_fib=0.
   - Raise start with value=8 in the done cycle → accepted; index=6, is_fib=1.
   - Confirm done is exactly 1 cycle wide and busy/done are mutually exclusive.
6. Loopback: chain fibonacci_gen fib output (n=0..13) into value → every result has is_fib=1, and index equals n except n=2, where the expected index is 1.
